mux_sel_rr_arbiter: RTL and testbench
=====================================

Name: mux_sel_rr_arbiter

Overview:
- Upstream control stage for the team's N:1 lane multiplexer (mux_nX1).
- Arbitrates N request lines round-robin and drives the mux select S together with a valid/ready handshake.
- Holds S stable until the downstream consumer accepts the selected lane.
- Output S connects directly to the mux S input; sel_valid/sel_ready pace the consumer of the mux output Y.

Parameters:
- N, 8, number of requesters/mux lanes; legal range N >= 2, not necessarily a power of two.
- TIMEOUT, 15, cycles a grant may wait for sel_ready before forced release; used only with MUX_SEL_TIMEOUT_EN; legal range 1..255.

Ports:
- clk, input, 1, rising-edge clock; the only clock.
- rst, input, 1, reset; synchronous, active-high.
- req, input, N, per-lane request; bit i requests lane i.
- sel_ready, input, 1, consumer accepts the current selection this cycle.
- S, output, $clog2(N), registered lane select; drives mux S.
- sel_valid, output, 1, registered; S is a live grant.
- grant, output, N, registered one-hot copy of S; all-zero when sel_valid = 0.
- timeout, output, 1, one-cycle pulse on forced release; present only with MUX_SEL_TIMEOUT_EN.

Behaviour:
- Reset values, applied at the first clk edge with rst = 1 (also mid-grant): S = 0, sel_valid = 0, grant = 0, timeout = 0, state = IDLE, last pointer = N-1 (so lane 0 wins first).
- Winner selection: the first set req bit searching from index last+1 upward, wrapping modulo N. Indices >= N are never produced, so S <= N-1 always.
- IDLE:
  - If |req = 1, register the winner into S/grant, set sel_valid = 1, and go to GRANT.
  - Latency: req asserted at edge k gives sel_valid = 1 after edge k+1.
- GRANT, sel_ready = 0: S, grant and sel_valid hold. A drop of the granted req does not retract the grant.
- GRANT, sel_ready = 1: the transfer completes this cycle, and last <= S.
  - Next winner is computed in the same cycle from the current req, searching from S+1.
  - If a winner exists: load it, keep sel_valid = 1, stay in GRANT. Back-to-back with no bubble.
  - Otherwise: sel_valid = 0, grant = 0, S holds its value, go to IDLE.
- Single requester held high with sel_ready = 1: it is re-granted every cycle.
- sel_ready while sel_valid = 0: ignored.
- Fairness: with all N requesting and sel_ready tied to 1, S cycles 0,1,...,N-1,0 with no repeats.

Optional Feature:
- Macro MUX_SEL_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on entry to GRANT and on each transfer, and increments each GRANT cycle with sel_ready = 0.
  - When the count reaches TIMEOUT: sel_valid and grant drop, last <= S (the stalled lane is skipped), timeout pulses for 1 cycle, go to IDLE.
  - Normal arbitration resumes on the next cycle.
- Undefined: no counter and no timeout port. A grant waits indefinitely.

Decomposition:
- Package mux_sel_pkg holds:
  - the state enum {IDLE, GRANT};
  - a function giving the select width, $clog2(N);
  - the timeout counter width constant (8).
- Sub-module rr_pick: purely combinational rotate-priority finder.
  - Inputs: req[N], start index.
  - Outputs: idx, found.
  - Instantiated once; the top holds all state.

Test Plan:
- Reset/idle: rst = 1 for 2 cycles, then req = 0 → S = 0, sel_valid = 0, grant = 0 on all cycles.
- First grant and latency: req = 8'b0000_0100, sel_ready = 0 → one cycle later S = 2, grant = 8'b0000_0100, sel_valid = 1; all held for 5 cycles even after req drops.
- Round-robin: req = 8'hFF, sel_ready = 1 → S sequence 0,1,2,...,7,0 on consecutive cycles, sel_valid continuously 1.
- Wrap-around and skip: last = 6, req = 8'b0100_0001 → next S = 0, then S = 6.
- Reset mid-grant: S = 5 with sel_valid = 1, assert rst for 1 cycle → sel_valid = 0, S = 0 next cycle; with req = 8'h20 afterwards, re-grant arrives with S = 5.
- Timeout (MUX_SEL_TIMEOUT_EN, TIMEOUT = 3): req = 8'b0000_0011, sel_ready = 0:
  - S = 0 for 3 waiting cycles, then timeout pulses and sel_valid drops;
  - the next grant is S = 1.

Source files
------------

// File: rtl/mux_sel_rr_arbiter_pkg.sv
// Shared declarations for the round-robin mux-select arbiter.
//   state_t    : arbiter state (IDLE, GRANT)
//   sel_width  : width of the lane select for N lanes
//   TO_CNT_W   : width of the grant wait counter (timeout build, MUX_SEL_TIMEOUT_EN)
package mux_sel_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int TO_CNT_W = 8;

  function automatic int sel_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/mux_sel_rr_arbiter_if.sv
// Handshake/select bundle between the arbiter, its requesters and the
// consumer of the mux output.
//   req       : per-lane request (N bits)
//   sel_ready : consumer accepts the current selection
//   S         : lane select, drives the mux S input
//   sel_valid : S is a live grant
//   grant     : one-hot copy of S, zero when idle
//   timeout   : forced-release pulse (only when MUX_SEL_TIMEOUT_EN is defined)
// Modports: master = arbiter side, slave = requester/consumer side.
interface mux_sel_rr_arbiter_if
  import mux_sel_pkg::*;
#(
  parameter int N = 8
) ();
  localparam int W = sel_width(N);

  logic [N-1:0] req;
  logic         sel_ready;
  logic [W-1:0] S;
  logic         sel_valid;
  logic [N-1:0] grant;
`ifdef MUX_SEL_TIMEOUT_EN
  logic         timeout;
`endif

  modport master (
    input  req,
    input  sel_ready,
    output S,
    output sel_valid,
`ifdef MUX_SEL_TIMEOUT_EN
    output timeout,
`endif
    output grant
  );

  modport slave (
    output req,
    output sel_ready,
    input  S,
    input  sel_valid,
`ifdef MUX_SEL_TIMEOUT_EN
    input  timeout,
`endif
    input  grant
  );
endinterface

// File: rtl/mux_sel_rr_arbiter_rr_pick.sv
// Combinational rotate-priority finder: returns the first set bit of req
// searching upward from index start (inclusive), wrapping modulo N.
//   req   : request vector (N bits)
//   start : first index to examine, must be < N
//   idx   : winning index (0 when nothing found)
//   found : at least one request is set
module rr_pick
  import mux_sel_pkg::*;
#(
  parameter int N = 8,
  localparam int W = sel_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         found
);

  logic [W:0]   sum  [N];
  logic [W-1:0] cand [N];
  logic [N-1:0] hit;

  // cand[gi] is the lane examined at search offset gi. start + gi never
  // exceeds 2N-2, so a single conditional subtract performs the modulo.
  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    assign sum[gi]  = {1'b0, start} + (W+1)'(gi);
    assign cand[gi] = (sum[gi] >= (W+1)'(N)) ? W'(sum[gi] - (W+1)'(N))
                                              : sum[gi][W-1:0];
    assign hit[gi]  = req[cand[gi]];
  end

  // Scan from the far end so the smallest offset wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (hit[k]) begin
        found = 1'b1;
        idx   = cand[k];
      end
    end
  end

endmodule

// File: rtl/mux_sel_rr_arbiter.sv
// Round-robin arbiter driving the select of an N:1 lane mux with a
// valid/ready handshake. The select is held until the consumer accepts;
// a transfer immediately re-arbitrates so back-to-back grants have no bubble.
// Optional feature macro: MUX_SEL_TIMEOUT_EN -- a grant stalled for TIMEOUT
// cycles is released, the stalled lane is skipped, and timeout pulses once.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : mux_sel_rr_arbiter_if.master (req, sel_ready, S, sel_valid, grant,
//         timeout)
module mux_sel_rr_arbiter
  import mux_sel_pkg::*;
#(
  parameter int N = 8
`ifdef MUX_SEL_TIMEOUT_EN
  , parameter int TIMEOUT = 15
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  mux_sel_rr_arbiter_if.master  bus
);

  localparam int W = sel_width(N);

  state_t       state_reg;
  logic [W-1:0] s_reg;
  logic [W-1:0] last_reg;
  logic         valid_reg;
  logic [N-1:0] grant_reg;
`ifdef MUX_SEL_TIMEOUT_EN
  logic [TO_CNT_W-1:0] cnt_reg;
  logic                timeout_reg;
`endif

  logic [W-1:0] base;
  logic [W-1:0] start;
  logic [W-1:0] pick_idx;
  logic         pick_found;
  logic [N-1:0] pick_onehot;

  // On a completing transfer the search must start after the lane just
  // served, which has not yet been written into last_reg.
  always_comb begin
    base  = (state_reg == GRANT && bus.sel_ready) ? s_reg : last_reg;
    start = (base == W'(N - 1)) ? '0 : base + 1'b1;
  end

  rr_pick #(.N(N)) u_pick (
    .req   (bus.req),
    .start (start),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    pick_onehot           = '0;
    pick_onehot[pick_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      s_reg       <= '0;
      last_reg    <= W'(N - 1);
      valid_reg   <= 1'b0;
      grant_reg   <= '0;
`ifdef MUX_SEL_TIMEOUT_EN
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
`endif
    end else begin
`ifdef MUX_SEL_TIMEOUT_EN
      timeout_reg <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (pick_found) begin
            s_reg     <= pick_idx;
            grant_reg <= pick_onehot;
            valid_reg <= 1'b1;
            state_reg <= GRANT;
`ifdef MUX_SEL_TIMEOUT_EN
            cnt_reg   <= '0;
`endif
          end
        end
        GRANT: begin
          if (bus.sel_ready) begin
            last_reg <= s_reg;
`ifdef MUX_SEL_TIMEOUT_EN
            cnt_reg  <= '0;
`endif
            if (pick_found) begin
              s_reg     <= pick_idx;
              grant_reg <= pick_onehot;
            end else begin
              // S keeps its last value; only valid and grant drop.
              valid_reg <= 1'b0;
              grant_reg <= '0;
              state_reg <= IDLE;
            end
          end
`ifdef MUX_SEL_TIMEOUT_EN
          else if (cnt_reg == TO_CNT_W'(TIMEOUT - 1)) begin
            // This stall cycle brings the count to TIMEOUT: release.
            last_reg    <= s_reg;
            valid_reg   <= 1'b0;
            grant_reg   <= '0;
            timeout_reg <= 1'b1;
            cnt_reg     <= '0;
            state_reg   <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
`endif
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.S         = s_reg;
  assign bus.sel_valid = valid_reg;
  assign bus.grant     = grant_reg;
`ifdef MUX_SEL_TIMEOUT_EN
  assign bus.timeout   = timeout_reg;
`endif

endmodule

// File: tb/tb_mux_sel_rr_arbiter.sv
// Self-checking bench for mux_sel_rr_arbiter: directed scenarios followed by
// randomized req/sel_ready/rst, every cycle compared with a behavioural model.
module tb_mux_sel_rr_arbiter;

  localparam int N = 8;
`ifdef MUX_SEL_TIMEOUT_EN
  localparam int TIMEOUT = 3;
`endif

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;

  mux_sel_rr_arbiter_if #(.N(N)) bus ();

`ifdef MUX_SEL_TIMEOUT_EN
  mux_sel_rr_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
`else
  mux_sel_rr_arbiter #(.N(N)) dut (
`endif
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: whether a grant is live, the granted lane, the last
  // served lane, how long the live grant has waited.
  bit m_valid;
  int m_s;
  int m_last;
  int m_wait;
  bit m_timeout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // First requesting lane after 'after', wrapping; -1 when none.
  function automatic int next_lane(input logic [N-1:0] r, input int after);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (after + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_edge(input bit r, input logic [N-1:0] rq, input bit rdy);
    int w;
    m_timeout = 1'b0;
    if (r) begin
      m_valid = 1'b0; m_s = 0; m_last = N - 1; m_wait = 0;
    end else if (!m_valid) begin
      w = next_lane(rq, m_last);
      if (w >= 0) begin
        m_valid = 1'b1; m_s = w; m_wait = 0;
      end
    end else if (rdy) begin
      $display("xfer lane %0d at %0t", m_s, $time);
      m_last = m_s;
      m_wait = 0;
      w = next_lane(rq, m_s);
      if (w >= 0) m_s = w;
      else m_valid = 1'b0;
    end else begin
`ifdef MUX_SEL_TIMEOUT_EN
      m_wait++;
      if (m_wait == TIMEOUT) begin
        m_valid = 1'b0; m_last = m_s; m_timeout = 1'b1; m_wait = 0;
      end
`endif
    end
  endtask

  // One clock: inputs already driven, advance the model, then compare.
  task automatic step();
    logic [N-1:0] rq;
    bit rdy;
    bit r;
    logic [N-1:0] g;
    rq = bus.req; rdy = bus.sel_ready; r = rst;
    @(posedge clk);
    model_edge(r, rq, rdy);
    #1;
    g = m_valid ? (N'(1) << m_s) : '0;
    chk("S", 32'(bus.S), 32'(m_s));
    chk("sel_valid", 32'(bus.sel_valid), 32'(m_valid));
    chk("grant", 32'(bus.grant), 32'(g));
`ifdef MUX_SEL_TIMEOUT_EN
    chk("timeout", 32'(bus.timeout), 32'(m_timeout));
`endif
  endtask

  task automatic drive(input bit r, input logic [N-1:0] rq, input bit rdy);
    rst = r; bus.req = rq; bus.sel_ready = rdy;
  endtask

  initial begin
    drive(1'b1, '0, 1'b0);
    #1;
    // Reset then idle.
    step(); step();
    drive(1'b0, '0, 1'b0);
    repeat (3) step();
    chk("idle_S", 32'(bus.S), 32'd0);

    // First grant, held while stalled even after req drops.
    drive(1'b0, 8'b0000_0100, 1'b0);
    step();
    chk("first_S", 32'(bus.S), 32'd2);
    chk("first_grant", 32'(bus.grant), 32'h04);
    drive(1'b0, '0, 1'b0);
`ifdef MUX_SEL_TIMEOUT_EN
    repeat (2) step();
`else
    repeat (5) step();
`endif
    chk("hold_valid", 32'(bus.sel_valid), 32'd1);
    drive(1'b0, '0, 1'b1);
    step();

    // Round-robin from reset: 0,1,...,7,0.
    drive(1'b1, '0, 1'b0); step();
    drive(1'b0, 8'hFF, 1'b1);
    for (int i = 0; i < N + 2; i++) begin
      step();
      chk("rr_seq", 32'(bus.S), 32'(i % N));
    end

    // Wrap-around and skip: last = 6, req = lanes 0 and 6.
    drive(1'b1, '0, 1'b0); step();
    drive(1'b0, 8'h40, 1'b0); step();
    drive(1'b0, 8'b0100_0001, 1'b1); step();
    chk("wrap_S0", 32'(bus.S), 32'd0);
    step();
    chk("wrap_S6", 32'(bus.S), 32'd6);
    drive(1'b0, '0, 1'b1); step(); step();

    // Reset mid-grant.
    drive(1'b1, '0, 1'b0); step();
    drive(1'b0, 8'h20, 1'b0); step();
    chk("mid_S5", 32'(bus.S), 32'd5);
    drive(1'b1, 8'h20, 1'b0); step();
    chk("mid_rst_valid", 32'(bus.sel_valid), 32'd0);
    drive(1'b0, 8'h20, 1'b0); step();
    chk("mid_regrant", 32'(bus.S), 32'd5);

`ifdef MUX_SEL_TIMEOUT_EN
    // Stalled grant is forced off and the other lane is served next.
    drive(1'b1, '0, 1'b0); step();
    drive(1'b0, 8'b0000_0011, 1'b0);
    repeat (4) step();
    chk("to_pulse", 32'(bus.timeout), 32'd1);
    step();
    chk("to_next", 32'(bus.S), 32'd1);
`endif

    // Randomized phase.
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] rq;
      case ($urandom_range(3))
        0: rq = N'($urandom);
        1: rq = N'($urandom & $urandom & $urandom);
        2: rq = N'(1) << $urandom_range(N - 1);
        default: rq = '0;
      endcase
      drive(($urandom_range(49) == 0), rq, ($urandom_range(2) != 0));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
